// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory target for the load/store port.
// Accepts a byte/half/word load or store on a valid/ready request channel, waits
// LATENCY cycles, commits against internal word storage, then holds the result on
// a valid/ready response channel until taken.
// Optional feature macro: DMEM_MISALIGN_ERR_EN (misaligned half/word -> rsp_err).
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [IDX_W-1:0] idx;
   logic [1:0]       off;
   logic             in_range, misalign, acc_err;
   logic [31:0]      rd_word, rd_shift, ld_data;
   logic [3:0]       wr_be;
   logic [31:0]      wr_data;
   logic             wr_en;

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Decode the captured request: word index, lane offset, fault and load data.
   always_comb begin
      idx      = addr_q[IDX_W+1:2];
      in_range = (addr_q[31:2] < 30'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_ERR_EN
      misalign = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      acc_err  = !in_range || misalign;
      // Half ignores addr[0] and word ignores addr[1:0]; misaligned cases
      // are already faulted when the error feature is enabled.
      case (size_q)
         2'b00:   off = addr_q[1:0];
         2'b01:   off = {addr_q[1], 1'b0};
         default: off = 2'b00;
      endcase
      rd_word  = mem[idx];
      rd_shift = rd_word >> {off, 3'b000};
      case (size_q)
         2'b00:   ld_data = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_data = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: ld_data = rd_shift;
      endcase
      // Store data is replicated across lanes so the byte enables pick the slot.
      case (size_q)
         2'b00:   begin wr_be = 4'b0001 << off; wr_data = {4{wdata_q[7:0]}};  end
         2'b01:   begin wr_be = 4'b0011 << off; wr_data = {2{wdata_q[15:0]}}; end
         default: begin wr_be = 4'b1111;        wr_data = wdata_q;            end
      endcase
      // Only a live COMMIT cycle may touch storage; reset discards it.
      wr_en = (state_q == S_COMMIT) && reset && wr_q && !acc_err;
   end

   // Next-state and output logic for the IDLE/WAIT/COMMIT/RESP sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      size_d      = size_q;
      uns_d       = uns_q;
      wdata_d     = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               cnt_d   = 4'(LATENCY);
               state_d = (LATENCY == 0) ? S_COMMIT : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || wr_q) ? 32'd0 : ld_data;
            state_d     = S_RESP;
         end
         default: begin
            if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
         end
      endcase
      // rsp_valid rises one cycle into RESP and drops on the handshake edge.
      rsp_valid_d = (state_q == S_RESP) && !(rsp_valid_q && rsp_ready);
      req_ready_d = (state_d == S_IDLE);
   end

   // Control and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= 32'd0;
         size_q      <= 2'd0;
         uns_q       <= 1'b0;
         wdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         wdata_q     <= wdata_d;
      end
   end

   // Byte-lane masked storage write; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder against
// a byte-addressed reference memory model.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] ref_mem [4*DEPTH];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed memory, natural-size access rounded down to
   // its own alignment unless misalignment is a fault.
   task automatic model(input bit w, input logic [31:0] a, input logic [1:0] sz,
                        input bit u, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err);
      int n;
      int base;
      bit mis;
      n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis  = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
      mis  = (a % n) != 0;
`endif
      err  = (a >= 32'(4*DEPTH)) || mis;
      rd   = 32'd0;
      if (!err) begin
         base = int'(a) - (int'(a) % n);
         if (w) begin
            for (int i = 0; i < n; i++) ref_mem[base+i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[base+i];
            if (!u && n < 4 && rd[8*n-1]) begin
               for (int i = 8*n; i < 32; i++) rd[i] = 1'b1;
            end
         end
      end
   endtask

   // One full transaction: accept, latency, response, optional backpressure.
   task automatic xact(input bit w, input logic [31:0] a, input logic [1:0] sz,
                       input bit u, input logic [31:0] wd, input int hold,
                       output logic [31:0] got_rd, output logic got_err);
      logic [31:0] exp_rd;
      bit          exp_err;
      int          cyc;
      bit          stable;
      logic [31:0] rd0;
      logic        e0;
      model(w, a, sz, u, wd, exp_rd, exp_err);
      req_write = w; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
      req_valid = 1'b1;
      rsp_ready = (hold == 0);
      cyc = 0;
      while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
      chk("accept_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin
         chk("busy_ready", {31'd0, req_ready}, 32'd0);
         @(posedge clk); #1; cyc++;
      end
      chk("latency", 32'(cyc), 32'(LAT + 2));
      chk("rdata", rsp_rdata, exp_rd);
      chk("err", {31'd0, rsp_err}, {31'd0, exp_err});
      got_rd  = rsp_rdata;
      got_err = rsp_err;
      if (hold > 0) begin
         rd0 = rsp_rdata; e0 = rsp_err; stable = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rd0 || rsp_err !== e0 || req_ready) stable = 1'b0;
         end
         chk("hold_stable", {31'd0, stable}, 32'd1);
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("valid_drop", {31'd0, rsp_valid}, 32'd0);
      chk("ready_back", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      bit          seen;
      int          cyc;
      logic [31:0] a;

      // Reset held with a pending request: nothing accepted, outputs quiet.
      reset = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
      req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D; rsp_ready = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_ready", {31'd0, req_ready}, 32'd0);
         chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_err", {31'd0, rsp_err}, 32'd0);
         chk("rst_rdata", rsp_rdata, 32'd0);
      end
      reset = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rel_ready", {31'd0, req_ready}, 32'd1);
      chk("rel_valid", {31'd0, rsp_valid}, 32'd0);

      // Give every word a defined value.
      for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(4*i), 2'd2, 1'b0, $urandom, 0, rd, er);

      // Word store then load.
      xact(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er);
      xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
      chk("t2_word", rd, 32'hDEADBEEF);

      // Byte store into a cleared word, signed/unsigned readback.
      xact(1'b1, 32'h20, 2'd2, 1'b0, 32'h0, 0, rd, er);
      xact(1'b1, 32'h21, 2'd0, 1'b0, 32'h80, 0, rd, er);
      xact(1'b0, 32'h21, 2'd0, 1'b0, 32'h0, 0, rd, er);
      chk("t3_sbyte", rd, 32'hFFFFFF80);
      xact(1'b0, 32'h20, 2'd1, 1'b1, 32'h0, 0, rd, er);
      chk("t3_uhalf", rd, 32'h00008000);
      xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, rd, er);
      chk("t3_word", rd, 32'h00008000);

      // Out of range: fault and no aliasing write to word 0.
      xact(1'b0, 32'h400, 2'd2, 1'b0, 32'h0, 0, rd, er);
      chk("t4_err", {31'd0, er}, 32'd1);
      xact(1'b1, 32'h400, 2'd2, 1'b0, 32'h55AA55AA, 0, rd, er);
      xact(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, rd, er);

      // Long backpressure.
      xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, rd, er);

      // Reset while a store to 0x8 is waiting: dropped, old value kept.
      req_write = 1'b1; req_addr = 32'h8; req_size = 2'd2; req_unsigned = 1'b0;
      req_wdata = 32'h12345678; req_valid = 1'b1; rsp_ready = 1'b1;
      cyc = 0;
      while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 1'b0;
      repeat (8) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
      rsp_ready = 1'b0;
      chk("t6_no_rsp", {31'd0, seen}, 32'd0);
      xact(1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 0, rd, er);

`ifdef DMEM_MISALIGN_ERR_EN
      xact(1'b0, 32'h6, 2'd2, 1'b0, 32'h0, 0, rd, er);
      chk("t6_misalign", {31'd0, er}, 32'd1);
`endif

      // Randomized mix of sizes, signedness, addresses and backpressure.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
         else                           a = 32'($urandom_range(0, 4*DEPTH-1));
         xact(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), rd, er);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
